button_conditioner: RTL and testbench

//  Input stage directly upstream of the calculator top (Button1, Button2, Equals, Reset, Operation).

---
 rtl/calc_pkg.sv | 30 +++
 rtl/button_debounce.sv | 133 +++++++++++++
 rtl/button_conditioner.sv | 41 ++++
 tb/tb_button_conditioner.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared calculator definitions.
// Purpose: button bit map, default timing constants and the per-button
//          state type, so the calculator top, the input conditioner and the
//          bench all agree on which bit is which button.
// Ports:   none (package).
package calc_pkg;

  localparam int unsigned N_BTN_DEF = 5;

  localparam int unsigned BTN_ONE    = 0;
  localparam int unsigned BTN_TWO    = 1;
  localparam int unsigned BTN_EQUALS = 2;
  localparam int unsigned BTN_CLEAR  = 3;
  localparam int unsigned BTN_OP     = 4;

  // 10 ms debounce, 500 ms first repeat, 100 ms repeat period at 50 MHz
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 500000;
  localparam int unsigned REPEAT_DELAY_DEF    = 25000000;
  localparam int unsigned REPEAT_RATE_DEF     = 5000000;

  // Only the digit buttons auto-repeat by default
  localparam logic [4:0] REPEAT_MASK_DEF = 5'b00011;

  typedef enum logic [1:0] {
    ST_RELEASED = 2'd0,
    ST_HELD     = 2'd1,
    ST_REPEAT   = 2'd2
  } btn_state_t;

endpackage

// File: rtl/button_debounce.sv
// Single push-button conditioner.
// Purpose: 2-flop synchroniser, debounce counter, press FSM with optional
//          auto-repeat for one raw button bit.
// Ports:
//   clk    in  1  system clock, rising edge
//   rst_n  in  1  asynchronous active-low reset, clears all state
//   raw    in  1  raw button pin, active-high, asynchronous to clk
//   level  out 1  debounced level, 1 = held
//   press  out 1  one-cycle strobe per accepted press and per auto-repeat
module button_debounce
  import calc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_RATE     = REPEAT_RATE_DEF,
  parameter bit          REPEAT_EN       = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int unsigned DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);

  function automatic logic [DB_W-1:0] db_inc(input logic [DB_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  function automatic logic [HOLD_W-1:0] hold_inc(input logic [HOLD_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  logic              sync_p0, sync_p1;
  logic [DB_W-1:0]   db_cnt, db_cnt_next;
  logic              level_next;
  logic              accept, rise, fall;
  btn_state_t        state, state_next;
  logic [HOLD_W-1:0] hold_cnt, hold_next;
  logic              press_next;

  // ---- stage p0/p1: synchroniser; debounce on the p1 value ----
  always_comb begin
    accept      = 1'b0;
    db_cnt_next = '0;
    level_next  = level;
    if (sync_p1 != level) begin
      // The window already holds DEBOUNCE_CYCLES differing cycles: take it
      if (db_cnt == DB_W'(DEBOUNCE_CYCLES)) begin
        accept     = 1'b1;
        level_next = sync_p1;
      end else begin
        db_cnt_next = db_inc(db_cnt);
      end
    end
  end

  assign rise = accept &  sync_p1;
  assign fall = accept & ~sync_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      db_cnt  <= '0;
      level   <= 1'b0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      db_cnt  <= db_cnt_next;
      level   <= level_next;
    end
  end

  // ---- press FSM: reacts to the same edge that updates level ----
  always_comb begin
    state_next = state;
    hold_next  = hold_cnt;
    press_next = 1'b0;
    unique case (state)
      ST_RELEASED: begin
        hold_next = '0;
        if (rise) begin
          state_next = ST_HELD;
          press_next = 1'b1;
        end
      end
      ST_HELD: begin
        if (fall) begin
          state_next = ST_RELEASED;
          hold_next  = '0;
        end else if (REPEAT_EN && (hold_cnt == HOLD_W'(REPEAT_DELAY - 1))) begin
          state_next = ST_REPEAT;
          press_next = 1'b1;
          hold_next  = '0;
        end else begin
          hold_next = hold_inc(hold_cnt);
        end
      end
      ST_REPEAT: begin
        if (fall) begin
          state_next = ST_RELEASED;
          hold_next  = '0;
        end else if (hold_cnt == HOLD_W'(REPEAT_RATE - 1)) begin
          press_next = 1'b1;
          hold_next  = '0;
        end else begin
          hold_next = hold_inc(hold_cnt);
        end
      end
      default: begin
        state_next = ST_RELEASED;
        hold_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RELEASED;
      hold_cnt <= '0;
      press    <= 1'b0;
    end else begin
      state    <= state_next;
      hold_cnt <= hold_next;
      press    <= press_next;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Calculator push-button input stage.
// Purpose: synchronise, debounce and strobe every raw button independently;
//          digit buttons may auto-repeat while held.
// Ports:
//   Clock        in  1      system clock, rising edge
//   Reset        in  1      asynchronous active-low reset, clears all state
//   BtnRaw       in  N_BTN  raw button pins, active-high, asynchronous
//   ButtonLevel  out N_BTN  debounced level per button, 1 = held
//   ButtonPress  out N_BTN  one-cycle strobe per accepted press / auto-repeat
module button_conditioner
  import calc_pkg::*;
#(
  parameter int unsigned      N_BTN           = N_BTN_DEF,
  parameter int unsigned      DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned      REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int unsigned      REPEAT_RATE     = REPEAT_RATE_DEF,
  parameter logic [N_BTN-1:0] REPEAT_MASK     = N_BTN'(REPEAT_MASK_DEF)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [N_BTN-1:0] BtnRaw,
  output logic [N_BTN-1:0] ButtonLevel,
  output logic [N_BTN-1:0] ButtonPress
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_RATE     (REPEAT_RATE),
      .REPEAT_EN       (REPEAT_MASK[i])
    ) u_btn (
      .clk   (Clock),
      .rst_n (Reset),
      .raw   (BtnRaw[i]),
      .level (ButtonLevel[i]),
      .press (ButtonPress[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;
  import calc_pkg::*;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic [4:0] BtnRaw = 5'b0;
  logic [4:0] ButtonLevel, ButtonPress;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  typedef struct {
    int         edge_at;
    logic [4:0] mask;
  } exp_t;
  exp_t exp_q[$];

  button_conditioner #(
    .N_BTN           (5),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (8),
    .REPEAT_RATE     (3),
    .REPEAT_MASK     (5'b00011)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .BtnRaw      (BtnRaw),
    .ButtonLevel (ButtonLevel),
    .ButtonPress (ButtonPress)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) edge_n <= edge_n + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, edge=%0d", edge_n);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at edge %0d: observed=%0h expected=%0h", tag, edge_n, obs, exp);
    end
  endtask

  task automatic expect_press(input int at, input logic [4:0] mask);
    exp_t e;
    e.edge_at = at;
    e.mask    = mask;
    exp_q.push_back(e);
  endtask

  // One clock: sample at the falling edge and pop every strobe due now
  task automatic tick();
    logic [4:0] want;
    want = '0;
    @(negedge Clock);
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].edge_at == edge_n) begin
        want = want | exp_q[i].mask;
        exp_q.delete(i);
      end
    end
    check("press", {27'b0, ButtonPress}, {27'b0, want});
  endtask

  task automatic run_to(input int target);
    while (edge_n < target) tick();
  endtask

  initial begin
    int k, a, e;

    // Reset held with every button down
    BtnRaw = 5'b11111;
    Reset  = 1'b0;
    run_to(4);
    check("rst_level", {27'b0, ButtonLevel}, 32'h0);
    Reset = 1'b1;
    k = edge_n + 1;
    expect_press(k + 6, 5'b11111);
    run_to(k + 5);
    check("rst_rel_level_before", {27'b0, ButtonLevel}, 32'h0);
    run_to(k + 6);
    check("rst_rel_level", {27'b0, ButtonLevel}, 32'h1f);
    BtnRaw = 5'b0;
    run_to(k + 12);
    check("rst_rel_fall_before", {27'b0, ButtonLevel}, 32'h1f);
    run_to(k + 13);
    check("rst_rel_fall", {27'b0, ButtonLevel}, 32'h0);
    run_to(edge_n + 5);

    // Clean press of Equals held 20 cycles, no repeat
    BtnRaw[BTN_EQUALS] = 1'b1;
    k = edge_n + 1;
    expect_press(k + 6, 5'b00100);
    run_to(k + 5);
    check("eq_level_before", {27'b0, ButtonLevel}, 32'h0);
    run_to(k + 6);
    check("eq_level", {27'b0, ButtonLevel}, 32'h4);
    run_to(k + 19);
    BtnRaw[BTN_EQUALS] = 1'b0;
    run_to(k + 20 + 5);
    check("eq_rel_before", {27'b0, ButtonLevel}, 32'h4);
    run_to(k + 20 + 6);
    check("eq_rel", {27'b0, ButtonLevel}, 32'h0);
    run_to(edge_n + 4);

    // Bounce on Button1: 1,0,1,0 then stable 1
    BtnRaw[BTN_ONE] = 1'b1; tick();
    BtnRaw[BTN_ONE] = 1'b0; tick();
    BtnRaw[BTN_ONE] = 1'b1; tick();
    BtnRaw[BTN_ONE] = 1'b0; tick();
    BtnRaw[BTN_ONE] = 1'b1;
    k = edge_n + 1;
    expect_press(k + 6, 5'b00001);
    run_to(k + 5);
    check("bounce_level_before", {27'b0, ButtonLevel}, 32'h0);
    run_to(k + 6);
    check("bounce_level", {27'b0, ButtonLevel}, 32'h1);
    BtnRaw[BTN_ONE] = 1'b0;
    run_to(k + 13);
    check("bounce_rel", {27'b0, ButtonLevel}, 32'h0);
    run_to(edge_n + 4);

    // Three-cycle glitch on Operation
    BtnRaw[BTN_OP] = 1'b1; tick(); tick(); tick();
    BtnRaw[BTN_OP] = 1'b0;
    run_to(edge_n + 10);
    check("glitch_level", {27'b0, ButtonLevel}, 32'h0);

    // Auto-repeat on Button2
    BtnRaw[BTN_TWO] = 1'b1;
    k = edge_n + 1;
    a = k + 6;
    expect_press(a,      5'b00010);
    expect_press(a + 8,  5'b00010);
    expect_press(a + 11, 5'b00010);
    expect_press(a + 14, 5'b00010);
    expect_press(a + 17, 5'b00010);
    run_to(a + 13);
    BtnRaw[BTN_TWO] = 1'b0;
    run_to(a + 19);
    check("rep_level_held", {27'b0, ButtonLevel}, 32'h2);
    run_to(a + 20);
    check("rep_level_rel", {27'b0, ButtonLevel}, 32'h0);
    run_to(a + 30);

    // Simultaneous press of Button1 and Operation
    BtnRaw = 5'b10001;
    k = edge_n + 1;
    expect_press(k + 6, 5'b10001);
    run_to(k + 6);
    check("simul_level", {27'b0, ButtonLevel}, 32'h11);
    BtnRaw = 5'b0;
    run_to(k + 13);
    check("simul_rel", {27'b0, ButtonLevel}, 32'h0);
    run_to(edge_n + 4);

    // Reset in the middle of auto-repeat, button still held afterwards
    BtnRaw[BTN_TWO] = 1'b1;
    k = edge_n + 1;
    a = k + 6;
    expect_press(a,     5'b00010);
    expect_press(a + 8, 5'b00010);
    run_to(a + 8);
    #1 Reset = 1'b0;
    #1;
    check("async_level", {27'b0, ButtonLevel}, 32'h0);
    check("async_press", {27'b0, ButtonPress}, 32'h0);
    tick();
    tick();
    Reset = 1'b1;
    e = edge_n;
    expect_press(e + 7, 5'b00010);
    run_to(e + 6);
    check("rst_mid_level_before", {27'b0, ButtonLevel}, 32'h0);
    run_to(e + 7);
    check("rst_mid_level", {27'b0, ButtonLevel}, 32'h2);
    BtnRaw[BTN_TWO] = 1'b0;
    run_to(e + 14);
    check("rst_mid_rel", {27'b0, ButtonLevel}, 32'h0);
    run_to(e + 20);

    check("scoreboard_empty", exp_q.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
